uart_tx_fifo: RTL

Byte FIFO plus transmit sequencer that sits between the APB UART register block and the TX serializer core. The register block pushes bytes written to TX_DATA. This block pops them one at a time and drives the TX core's data_in/tx_en handshake, sequencing on its busy/done outputs. Software no longer has to manage tx_en retriggering per byte.

---
 rtl/uart_pkg.sv | 24 ++
 rtl/uart_sync_fifo.sv | 85 ++++++++
 rtl/uart_tx_fifo.sv | 85 ++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the UART slice: TX sequencer state encoding and the
// CTRL/STATS register bit positions used by the APB register block.
package uart_pkg;

    localparam int unsigned DEFAULT_DATA_W = 8;

    typedef enum logic [1:0] {
        StIdle     = 2'd0,
        StStart    = 2'd1,
        StWaitDone = 2'd2,
        StGap      = 2'd3
    } tx_state_e;

    localparam int unsigned CTRL_TX_EN_BIT   = 0;
    localparam int unsigned CTRL_RX_EN_BIT   = 1;
    localparam int unsigned CTRL_FLUSH_BIT   = 2;
    localparam int unsigned CTRL_OVF_CLR_BIT = 3;

    localparam int unsigned STATS_FULL_BIT   = 0;
    localparam int unsigned STATS_EMPTY_BIT  = 1;
    localparam int unsigned STATS_OVF_BIT    = 2;
    localparam int unsigned STATS_BUSY_BIT   = 3;

endpackage

// File: rtl/uart_sync_fifo.sv
// Byte FIFO with registered occupancy, full/empty flags and a sticky overflow
// flag; flush drops all queued entries and clears overflow.
module uart_sync_fifo #(
    parameter int unsigned DEPTH  = 16,
    parameter int unsigned DATA_W = 8,
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1
) (
    input  logic              PCLK,
    input  logic              PRESETn,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    output logic [DATA_W-1:0] rd_data,
    input  logic              flush,
    input  logic              ovf_clr,
    output logic              full,
    output logic              empty,
    output logic [CNT_W-1:0]  count,
    output logic              overflow
);

    localparam int unsigned PTR_W = $clog2(DEPTH);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              overflow_q, overflow_d;
    logic              push, pop, reject;

    assign full     = (count_q == CNT_W'(DEPTH));
    assign empty    = (count_q == '0);
    assign count    = count_q;
    assign overflow = overflow_q;
    assign rd_data  = mem_q[rd_ptr_q];

    // Full is judged on the registered count, so a same-cycle pop does not make room.
    always_comb begin
        push       = wr_en && !full && !flush;
        reject     = wr_en && full && !flush;
        pop        = rd_en && !empty;
        count_d    = count_q;
        overflow_d = overflow_q;
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
        if (flush) begin
            count_d    = '0;
            overflow_d = 1'b0;
        end else if (reject) begin
            overflow_d = 1'b1;
        end else if (ovf_clr) begin
            overflow_d = 1'b0;
        end
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            count_q    <= count_d;
            overflow_q <= overflow_d;
            if (flush) begin
                wr_ptr_q <= '0;
                rd_ptr_q <= '0;
            end else begin
                if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
                if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
        end
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
        end else if (push) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

endmodule

// File: rtl/uart_tx_fifo.sv
// TX byte queue plus sequencer: pops one byte at a time and drives the TX core's
// data_in/tx_en handshake, pacing itself on the core's busy/done outputs.
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int unsigned DEPTH  = 16,
    parameter int unsigned DATA_W = DEFAULT_DATA_W,
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1
) (
    input  logic              PCLK,
    input  logic              PRESETn,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              flush,
    input  logic              ovf_clr,
    output logic              full,
    output logic              empty,
    output logic [CNT_W-1:0]  count,
    output logic              overflow,
    output logic [DATA_W-1:0] tx_data,
    output logic              tx_en,
    input  logic              tx_busy,
    input  logic              tx_done,
    output logic              seq_active
);

    tx_state_e         state_q, state_d;
    logic [DATA_W-1:0] tx_data_q;
    logic              tx_en_q;
    logic              pop;
    logic [DATA_W-1:0] rd_data;

    uart_sync_fifo #(
        .DEPTH  (DEPTH),
        .DATA_W (DATA_W)
    ) u_fifo (
        .PCLK     (PCLK),
        .PRESETn  (PRESETn),
        .wr_en    (wr_en),
        .wr_data  (wr_data),
        .rd_en    (pop),
        .rd_data  (rd_data),
        .flush    (flush),
        .ovf_clr  (ovf_clr),
        .full     (full),
        .empty    (empty),
        .count    (count),
        .overflow (overflow)
    );

    always_comb begin
        state_d = state_q;
        pop     = 1'b0;
        case (state_q)
            StIdle: begin
                if (!empty && !tx_busy) begin
                    pop     = 1'b1;
                    state_d = StStart;
                end
            end
            StStart:    if (tx_busy) state_d = StWaitDone;
            StWaitDone: if (tx_done) state_d = StGap;
            StGap:      state_d = StIdle;
            default:    state_d = StIdle;
        endcase
    end

    // tx_en is registered from the next state so it drops as soon as busy is seen.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state_q   <= StIdle;
            tx_en_q   <= 1'b0;
            tx_data_q <= '0;
        end else begin
            state_q <= state_d;
            tx_en_q <= (state_d == StStart);
            if (pop) tx_data_q <= rd_data;
        end
    end

    assign tx_data    = tx_data_q;
    assign tx_en      = tx_en_q;
    assign seq_active = (state_q != StIdle);

endmodule
